// File: rtl/prf_read_arbiter_pkg.sv
// Shared constants and helpers for the PRF read-port arbiter.
// Lane numbering follows the issue-lane order ALU, LS, BR.
package prf_read_arbiter_pkg;

    localparam int NUM_ISSUE_LANES = 3;
    localparam int LANE_ALU = 0;
    localparam int LANE_LS = 1;
    localparam int LANE_BR = 2;

    localparam int PORT_IDX_W = 3;

    typedef logic [1:0] lane_idx_t;

    function automatic lane_idx_t lane_wrap(input int v);
        return lane_idx_t'(v % NUM_ISSUE_LANES);
    endfunction

endpackage

// File: rtl/prf_read_arbiter_if.sv
// Request/grant, PRF read-port and operand-response bundle.
// master: issue lanes + PRF array; slave: the arbiter.
interface prf_read_arbiter_if #(
    parameter int PHY_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH = 5,
    parameter int NUM_RD_PORTS = 4
) ();
    import prf_read_arbiter_pkg::*;

    logic [NUM_ISSUE_LANES-1:0] req_valid;
    logic [NUM_ISSUE_LANES-1:0] req_use_rs1;
    logic [NUM_ISSUE_LANES-1:0] req_use_rs2;
    logic [NUM_ISSUE_LANES*PHY_WIDTH-1:0] req_rs1;
    logic [NUM_ISSUE_LANES*PHY_WIDTH-1:0] req_rs2;
    logic [NUM_ISSUE_LANES*ROB_WIDTH-1:0] req_tag;
    logic [NUM_ISSUE_LANES-1:0] req_ready;

    logic [NUM_RD_PORTS-1:0] prf_ren;
    logic [NUM_RD_PORTS*PHY_WIDTH-1:0] prf_raddr;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] prf_rdata;

    logic [NUM_ISSUE_LANES-1:0] rsp_valid;
    logic [NUM_ISSUE_LANES*DATA_WIDTH-1:0] rsp_rs1_data;
    logic [NUM_ISSUE_LANES*DATA_WIDTH-1:0] rsp_rs2_data;
    logic [NUM_ISSUE_LANES*ROB_WIDTH-1:0] rsp_tag;

    modport master (
        output req_valid, req_use_rs1, req_use_rs2,
        output req_rs1, req_rs2, req_tag, prf_rdata,
        input req_ready, prf_ren, prf_raddr,
        input rsp_valid, rsp_rs1_data, rsp_rs2_data, rsp_tag
    );

    modport slave (
        input req_valid, req_use_rs1, req_use_rs2,
        input req_rs1, req_rs2, req_tag, prf_rdata,
        output req_ready, prf_ren, prf_raddr,
        output rsp_valid, rsp_rs1_data, rsp_rs2_data, rsp_tag
    );

endinterface

// File: rtl/prf_read_arbiter_alloc.sv
// Combinational priority walk: starved lanes first, then the rest,
// each group in round-robin order; ports filled lowest index first.
module prf_port_alloc
    import prf_read_arbiter_pkg::*;
#(
    parameter int PHY_WIDTH = 6,
    parameter int NUM_RD_PORTS = 4
) (
    input  logic [1:0] rr_ptr,
    input  logic [NUM_ISSUE_LANES-1:0] valid,
    input  logic [NUM_ISSUE_LANES-1:0] starved,
    input  logic [NUM_ISSUE_LANES-1:0] use_rs1,
    input  logic [NUM_ISSUE_LANES-1:0] use_rs2,
    input  logic [NUM_ISSUE_LANES-1:0][PHY_WIDTH-1:0] rs1,
    input  logic [NUM_ISSUE_LANES-1:0][PHY_WIDTH-1:0] rs2,
    output logic [NUM_ISSUE_LANES-1:0] grant,
    output lane_idx_t top_lane,
    output logic [NUM_RD_PORTS-1:0] ren,
    output logic [NUM_RD_PORTS-1:0][PHY_WIDTH-1:0] raddr,
    output logic [NUM_ISSUE_LANES-1:0][PORT_IDX_W-1:0] rs1_port,
    output logic [NUM_ISSUE_LANES-1:0][PORT_IDX_W-1:0] rs2_port
);

    always_comb begin
        int free;
        int nxt;
        int need;
        lane_idx_t lane;
        logic shared;
        logic found;
        grant = '0;
        top_lane = '0;
        ren = '0;
        raddr = '0;
        rs1_port = '0;
        rs2_port = '0;
        free = NUM_RD_PORTS;
        nxt = 0;
        need = 0;
        lane = '0;
        shared = 1'b0;
        found = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NUM_ISSUE_LANES; k++) begin
                lane = lane_wrap(int'(rr_ptr) + k);
                if (valid[lane] && (starved[lane] == (pass == 0))) begin
                    // Identical sources share one port.
                    shared = use_rs1[lane] && use_rs2[lane] &&
                             (rs1[lane] == rs2[lane]);
                    need = int'(use_rs1[lane]) + int'(use_rs2[lane])
                         - int'(shared);
                    if (need <= free) begin
                        grant[lane] = 1'b1;
                        if (!found) begin
                            found = 1'b1;
                            top_lane = lane;
                        end
                        if (use_rs1[lane]) begin
                            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                                if (p == nxt) begin
                                    ren[p] = 1'b1;
                                    raddr[p] = rs1[lane];
                                end
                            end
                            rs1_port[lane] = PORT_IDX_W'(nxt);
                            nxt = nxt + 1;
                        end
                        if (use_rs2[lane]) begin
                            if (shared) begin
                                rs2_port[lane] = rs1_port[lane];
                            end else begin
                                for (int p = 0; p < NUM_RD_PORTS; p++) begin
                                    if (p == nxt) begin
                                        ren[p] = 1'b1;
                                        raddr[p] = rs2[lane];
                                    end
                                end
                                rs2_port[lane] = PORT_IDX_W'(nxt);
                                nxt = nxt + 1;
                            end
                        end
                        free = free - need;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/prf_read_arbiter.sv
// Shares PRF read ports among the ALU/LS/BR issue lanes with
// round-robin + starvation priority and one-cycle operand return.
module prf_read_arbiter
    import prf_read_arbiter_pkg::*;
#(
    parameter int PHY_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH = 5,
    parameter int NUM_RD_PORTS = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic clk,
    input logic rst,
    input logic flush,
    prf_read_arbiter_if.slave bus
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int NL = NUM_ISSUE_LANES;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic [PHY_WIDTH-1:0] rs1;
        logic [PHY_WIDTH-1:0] rs2;
        logic [ROB_WIDTH-1:0] tag;
    } prf_rd_req_t;

    prf_rd_req_t req [NL];
    logic [NL-1:0][PHY_WIDTH-1:0] rs1_v;
    logic [NL-1:0][PHY_WIDTH-1:0] rs2_v;

    logic [1:0] rr_ptr;
    logic [NL-1:0][AGE_W-1:0] age;
    logic [NL-1:0] starved;
    logic [NL-1:0] act_valid;
    logic [NL-1:0] grant;
    lane_idx_t top_lane;
    logic [NUM_RD_PORTS-1:0] ren;
    logic [NUM_RD_PORTS-1:0][PHY_WIDTH-1:0] raddr;
    logic [NL-1:0][PORT_IDX_W-1:0] rs1_port;
    logic [NL-1:0][PORT_IDX_W-1:0] rs2_port;

    logic [NL-1:0][DATA_WIDTH-1:0] d1;
    logic [NL-1:0][DATA_WIDTH-1:0] d2;

    logic [NL-1:0] rsp_valid_q;
    logic [NL-1:0][DATA_WIDTH-1:0] rsp1_q;
    logic [NL-1:0][DATA_WIDTH-1:0] rsp2_q;
    logic [NL-1:0][ROB_WIDTH-1:0] tag_q;

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            req[i].use_rs1 = bus.req_use_rs1[i];
            req[i].use_rs2 = bus.req_use_rs2[i];
            req[i].rs1 = bus.req_rs1[i*PHY_WIDTH +: PHY_WIDTH];
            req[i].rs2 = bus.req_rs2[i*PHY_WIDTH +: PHY_WIDTH];
            req[i].tag = bus.req_tag[i*ROB_WIDTH +: ROB_WIDTH];
            rs1_v[i] = req[i].rs1;
            rs2_v[i] = req[i].rs2;
            starved[i] = (age[i] == AGE_W'(STARVE_LIMIT));
        end
    end

    // Nothing is granted while reset or flush is active.
    assign act_valid = bus.req_valid & ~{NL{flush | rst}};

    prf_port_alloc #(
        .PHY_WIDTH(PHY_WIDTH),
        .NUM_RD_PORTS(NUM_RD_PORTS)
    ) u_alloc (
        .rr_ptr(rr_ptr),
        .valid(act_valid),
        .starved(starved),
        .use_rs1(bus.req_use_rs1),
        .use_rs2(bus.req_use_rs2),
        .rs1(rs1_v),
        .rs2(rs2_v),
        .grant(grant),
        .top_lane(top_lane),
        .ren(ren),
        .raddr(raddr),
        .rs1_port(rs1_port),
        .rs2_port(rs2_port)
    );

    always_comb begin
        d1 = '0;
        d2 = '0;
        for (int i = 0; i < NL; i++) begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (req[i].use_rs1 && rs1_port[i] == PORT_IDX_W'(p))
                    d1[i] = bus.prf_rdata[p*DATA_WIDTH +: DATA_WIDTH];
                if (req[i].use_rs2 && rs2_port[i] == PORT_IDX_W'(p))
                    d2[i] = bus.prf_rdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            age <= '0;
            rsp_valid_q <= '0;
            rsp1_q <= '0;
            rsp2_q <= '0;
            tag_q <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                rsp_valid_q[i] <= grant[i];
                rsp1_q[i] <= grant[i] ? d1[i] : '0;
                rsp2_q[i] <= grant[i] ? d2[i] : '0;
                tag_q[i] <= grant[i] ? req[i].tag : '0;
                if (flush || !bus.req_valid[i] || grant[i])
                    age[i] <= '0;
                else if (!starved[i])
                    age[i] <= age[i] + AGE_W'(1);
            end
            if (|grant)
                rr_ptr <= lane_wrap(int'(top_lane) + 1);
        end
    end

    assign bus.req_ready = grant;
    assign bus.prf_ren = ren;
    assign bus.prf_raddr = raddr;
    assign bus.rsp_valid = rsp_valid_q & ~{NL{flush}};
    assign bus.rsp_rs1_data = rsp1_q;
    assign bus.rsp_rs2_data = rsp2_q;
    assign bus.rsp_tag = tag_q;

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Bench for prf_read_arbiter: directed scenarios plus randomized
// traffic against a queue-based priority/port-allocation model.
module tb_prf_read_arbiter;
    import prf_read_arbiter_pkg::*;

    localparam int PW = 6;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int NP = 4;
    localparam int LIM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    prf_read_arbiter_if #(.PHY_WIDTH(PW), .DATA_WIDTH(DW),
        .ROB_WIDTH(RW), .NUM_RD_PORTS(NP)) ia ();
    prf_read_arbiter_if #(.PHY_WIDTH(PW), .DATA_WIDTH(DW),
        .ROB_WIDTH(RW), .NUM_RD_PORTS(2)) ib ();

    prf_read_arbiter #(.PHY_WIDTH(PW), .DATA_WIDTH(DW), .ROB_WIDTH(RW),
        .NUM_RD_PORTS(NP), .STARVE_LIMIT(LIM)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .bus(ia));

    prf_read_arbiter #(.PHY_WIDTH(PW), .DATA_WIDTH(DW), .ROB_WIDTH(RW),
        .NUM_RD_PORTS(2), .STARVE_LIMIT(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .bus(ib));

    logic [DW-1:0] mem [64];

    always_comb begin
        for (int p = 0; p < NP; p++)
            ia.prf_rdata[p*DW +: DW] = mem[ia.prf_raddr[p*PW +: PW]];
        for (int p = 0; p < 2; p++)
            ib.prf_rdata[p*DW +: DW] = mem[ib.prf_raddr[p*PW +: PW]];
    end

    bit v [3];
    bit u1 [3];
    bit u2 [3];
    int r1 [3];
    int r2 [3];
    int tg [3];
    int checks = 0;
    int errors = 0;

    int m_rr;
    int m_age [3];
    int m_first;
    logic [2:0] exp_ready;
    logic [2:0] g_prev;
    logic [NP-1:0] exp_ren;
    logic [NP*PW-1:0] exp_raddr;
    logic [2:0] er_v;
    logic [3*DW-1:0] er_d1, er_d2, nx_d1, nx_d2;
    logic [3*RW-1:0] er_tag, nx_tag;

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            ia.req_valid[i] = v[i];
            ia.req_use_rs1[i] = u1[i];
            ia.req_use_rs2[i] = u2[i];
            ia.req_rs1[i*PW +: PW] = PW'(r1[i]);
            ia.req_rs2[i*PW +: PW] = PW'(r2[i]);
            ia.req_tag[i*RW +: RW] = RW'(tg[i]);
            ib.req_valid[i] = v[i];
            ib.req_use_rs1[i] = u1[i];
            ib.req_use_rs2[i] = u2[i];
            ib.req_rs1[i*PW +: PW] = PW'(r1[i]);
            ib.req_rs2[i*PW +: PW] = PW'(r2[i]);
            ib.req_tag[i*RW +: RW] = RW'(tg[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input bit vv, input bit a,
                            input bit b, input int x, input int y,
                            input int t);
        v[i] = vv; u1[i] = a; u2[i] = b;
        r1[i] = x; r2[i] = y; tg[i] = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) set_lane(i, 0, 0, 0, 0, 0, 0);
        drive();
        tick();
        tick();
        rst = 1'b0;
        m_rr = 0;
        for (int i = 0; i < 3; i++) m_age[i] = 0;
        er_v = '0; er_d1 = '0; er_d2 = '0; er_tag = '0;
        g_prev = '0;
    endtask

    // Priority list: starved lanes in rr order, then the others.
    function automatic void model_eval();
        int order[$];
        int free, p, n, l;
        bit sh;
        exp_ready = '0; exp_ren = '0; exp_raddr = '0;
        nx_d1 = '0; nx_d2 = '0; nx_tag = '0;
        m_first = -1;
        if (!flush) begin
            for (int k = 0; k < 3; k++) begin
                l = (m_rr + k) % 3;
                if (v[l] && m_age[l] == LIM) order.push_back(l);
            end
            for (int k = 0; k < 3; k++) begin
                l = (m_rr + k) % 3;
                if (v[l] && m_age[l] != LIM) order.push_back(l);
            end
            free = NP;
            p = 0;
            foreach (order[j]) begin
                l = order[j];
                sh = u1[l] && u2[l] && (r1[l] == r2[l]);
                n = int'(u1[l]) + int'(u2[l]) - int'(sh);
                if (n <= free) begin
                    exp_ready[l] = 1'b1;
                    if (m_first < 0) m_first = l;
                    if (u1[l]) begin
                        exp_ren[p] = 1'b1;
                        exp_raddr[p*PW +: PW] = PW'(r1[l]);
                        p++;
                    end
                    if (u2[l] && !sh) begin
                        exp_ren[p] = 1'b1;
                        exp_raddr[p*PW +: PW] = PW'(r2[l]);
                        p++;
                    end
                    free -= n;
                    nx_d1[l*DW +: DW] = u1[l] ? mem[r1[l]] : '0;
                    nx_d2[l*DW +: DW] = u2[l] ? mem[r2[l]] : '0;
                    nx_tag[l*RW +: RW] = RW'(tg[l]);
                end
            end
        end
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < 3; i++) begin
            if (flush || !v[i] || exp_ready[i]) m_age[i] = 0;
            else if (m_age[i] < LIM) m_age[i]++;
        end
        if (!flush && m_first >= 0) m_rr = (m_first + 1) % 3;
        er_v = exp_ready;
        er_d1 = nx_d1; er_d2 = nx_d2; er_tag = nx_tag;
        g_prev = exp_ready;
    endfunction

    task automatic test_reset();
        drive();
        #1;
        checks++;
        if (ia.req_ready !== 3'b000 || ia.prf_ren !== 4'b0000) begin
            errors++;
            $display("FAIL reset_init ready=%b ren=%b want 0", ia.req_ready, ia.prf_ren);
        end
        checks++;
        if (ia.rsp_valid !== 3'b000 || ia.rsp_tag !== '0) begin
            errors++;
            $display("FAIL reset_rsp valid=%b tag=%h want 0", ia.rsp_valid, ia.rsp_tag);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) set_lane(i, 1, 1, 1, 2*i+1, 2*i+2, i+3);
        drive();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ia.req_ready !== 3'b000 || ia.prf_ren !== 4'b0000 || ia.prf_raddr !== '0) begin
            errors++;
            $display("FAIL reset_mid_req ready=%b ren=%b raddr=%h want 0",
                     ia.req_ready, ia.prf_ren, ia.prf_raddr);
        end
        checks++;
        if (ia.rsp_valid !== 3'b000 || ia.rsp_rs1_data !== '0 || ia.rsp_tag !== '0) begin
            errors++;
            $display("FAIL reset_mid_rsp valid=%b d1=%h tag=%h want 0",
                     ia.rsp_valid, ia.rsp_rs1_data, ia.rsp_tag);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 3; i++) set_lane(i, 1, 1, 1, 2*i+1, 2*i+2, i+3);
        drive();
        #1;
        checks++;
        if (ia.req_ready !== 3'b011 || ia.prf_ren !== 4'b1111) begin
            errors++;
            $display("FAIL cont_grant ready=%b ren=%b want 011 1111", ia.req_ready, ia.prf_ren);
        end
        checks++;
        if (ia.prf_raddr !== {6'd4, 6'd3, 6'd2, 6'd1}) begin
            errors++;
            $display("FAIL cont_raddr got %h want %h", ia.prf_raddr, {6'd4, 6'd3, 6'd2, 6'd1});
        end
        tick();
        v[0] = 0; v[1] = 0;
        drive();
        #1;
        checks++;
        if (ia.req_ready !== 3'b100 || ia.prf_ren !== 4'b0011 ||
            ia.prf_raddr !== {12'd0, 6'd6, 6'd5}) begin
            errors++;
            $display("FAIL cont_br ready=%b ren=%b raddr=%h want 100 0011 000185",
                     ia.req_ready, ia.prf_ren, ia.prf_raddr);
        end
        checks++;
        if (ia.rsp_valid !== 3'b011 ||
            ia.rsp_rs1_data[63:0] !== {mem[3], mem[1]} ||
            ia.rsp_rs2_data[63:0] !== {mem[4], mem[2]} ||
            ia.rsp_tag[9:0] !== {5'd4, 5'd3}) begin
            errors++;
            $display("FAIL cont_rsp valid=%b d1=%h d2=%h want 011 %h %h",
                     ia.rsp_valid, ia.rsp_rs1_data[63:0], ia.rsp_rs2_data[63:0],
                     {mem[3], mem[1]}, {mem[4], mem[2]});
        end
        tick();
        v[2] = 0;
        drive();
        #1;
        checks++;
        if (ia.rsp_valid !== 3'b100 || ia.rsp_rs1_data[95:64] !== mem[5] ||
            ia.rsp_rs2_data[95:64] !== mem[6] || ia.rsp_tag[14:10] !== 5'd5) begin
            errors++;
            $display("FAIL cont_rsp_br valid=%b d1=%h d2=%h want 100 %h %h",
                     ia.rsp_valid, ia.rsp_rs1_data[95:64], ia.rsp_rs2_data[95:64],
                     mem[5], mem[6]);
        end
        tick();
        checks++;
        if (ia.rsp_valid !== 3'b000) begin
            errors++;
            $display("FAIL cont_one_cycle valid=%b want 000", ia.rsp_valid);
        end
    endtask

    task automatic test_shared();
        do_reset();
        mem[7] = 32'hDEADBEEF;
        set_lane(0, 1, 1, 1, 7, 7, 9);
        drive();
        #1;
        checks++;
        if (ia.prf_ren !== 4'b0001 || ia.prf_raddr !== 24'd7 || ia.req_ready !== 3'b001) begin
            errors++;
            $display("FAIL shared_port ren=%b raddr=%h ready=%b want 0001 7 001",
                     ia.prf_ren, ia.prf_raddr, ia.req_ready);
        end
        tick();
        v[0] = 0;
        drive();
        #1;
        checks++;
        if (ia.rsp_valid !== 3'b001 || ia.rsp_rs1_data[31:0] !== 32'hDEADBEEF ||
            ia.rsp_rs2_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL shared_data valid=%b d1=%h d2=%h want 001 deadbeef",
                     ia.rsp_valid, ia.rsp_rs1_data[31:0], ia.rsp_rs2_data[31:0]);
        end
    endtask

    task automatic test_zero_need();
        do_reset();
        set_lane(0, 1, 1, 1, 10, 11, 1);
        set_lane(1, 1, 1, 1, 12, 13, 2);
        set_lane(2, 1, 0, 0, 9, 8, 5'h15);
        drive();
        #1;
        checks++;
        if (ia.req_ready !== 3'b111 || ia.prf_ren !== 4'b1111) begin
            errors++;
            $display("FAIL zero_grant ready=%b ren=%b want 111 1111", ia.req_ready, ia.prf_ren);
        end
        tick();
        for (int i = 0; i < 3; i++) v[i] = 0;
        drive();
        #1;
        checks++;
        if (ia.rsp_valid[2] !== 1'b1 || ia.rsp_rs1_data[95:64] !== '0 ||
            ia.rsp_rs2_data[95:64] !== '0 || ia.rsp_tag[14:10] !== 5'h15) begin
            errors++;
            $display("FAIL zero_rsp valid=%b d1=%h d2=%h tag=%h want 1 0 0 15",
                     ia.rsp_valid[2], ia.rsp_rs1_data[95:64],
                     ia.rsp_rs2_data[95:64], ia.rsp_tag[14:10]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_lane(1, 1, 1, 0, 20, 0, 6);
        drive();
        #1;
        checks++;
        if (ia.req_ready !== 3'b010) begin
            errors++;
            $display("FAIL flush_pre ready=%b want 010", ia.req_ready);
        end
        tick();
        for (int i = 0; i < 3; i++) set_lane(i, 1, 1, 1, 30+2*i, 31+2*i, i);
        flush = 1'b1;
        drive();
        #1;
        checks++;
        if (ia.req_ready !== 3'b000 || ia.prf_ren !== 4'b0000 || ia.rsp_valid !== 3'b000) begin
            errors++;
            $display("FAIL flush_mask ready=%b ren=%b rsp=%b want 0",
                     ia.req_ready, ia.prf_ren, ia.rsp_valid);
        end
        tick();
        flush = 1'b0;
        drive();
        #1;
        checks++;
        if (ia.rsp_valid !== 3'b000 || ia.req_ready !== 3'b101) begin
            errors++;
            $display("FAIL flush_after rsp=%b ready=%b want 000 101",
                     ia.rsp_valid, ia.req_ready);
        end
        tick();
        for (int i = 0; i < 3; i++) v[i] = 0;
        drive();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (!(v[i] && !g_prev[i])) begin
                    v[i] = ($urandom % 4) != 0;
                    u1[i] = $urandom % 2;
                    u2[i] = $urandom % 2;
                    r1[i] = $urandom % 64;
                    r2[i] = ($urandom % 4 == 0) ? r1[i] : int'($urandom % 64);
                    tg[i] = $urandom % 32;
                end
            end
            flush = ($urandom % 12) == 0;
            drive();
            #1;
            model_eval();
            checks++;
            if (ia.req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_ready c=%0d got %b want %b", c, ia.req_ready, exp_ready);
            end
            checks++;
            if (ia.prf_ren !== exp_ren || ia.prf_raddr !== exp_raddr) begin
                errors++;
                $display("FAIL rnd_port c=%0d ren=%b raddr=%h want %b %h",
                         c, ia.prf_ren, ia.prf_raddr, exp_ren, exp_raddr);
            end
            checks++;
            if (ia.rsp_valid !== (er_v & ~{3{flush}})) begin
                errors++;
                $display("FAIL rnd_rsp_valid c=%0d got %b want %b",
                         c, ia.rsp_valid, er_v & ~{3{flush}});
            end
            checks++;
            if (ia.rsp_rs1_data !== er_d1 || ia.rsp_rs2_data !== er_d2) begin
                errors++;
                $display("FAIL rnd_rsp_data c=%0d d1=%h d2=%h want %h %h",
                         c, ia.rsp_rs1_data, ia.rsp_rs2_data, er_d1, er_d2);
            end
            checks++;
            if (ia.rsp_tag !== er_tag) begin
                errors++;
                $display("FAIL rnd_rsp_tag c=%0d got %h want %h", c, ia.rsp_tag, er_tag);
            end
            model_commit();
        end
        flush = 1'b0;
    endtask

    task automatic test_starve();
        do_reset();
        set_lane(0, 1, 1, 1, 11, 12, 1);
        set_lane(1, 1, 1, 0, 13, 0, 2);
        set_lane(2, 1, 1, 0, 14, 0, 3);
        drive();
        #1;
        checks++;
        if (ib.req_ready !== 3'b001 || ib.prf_raddr !== {6'd12, 6'd11}) begin
            errors++;
            $display("FAIL starve_c0 ready=%b raddr=%h want 001 30b",
                     ib.req_ready, ib.prf_raddr);
        end
        tick();
        drive();
        #1;
        checks++;
        if (ib.req_ready !== 3'b110 || ib.prf_raddr !== {6'd14, 6'd13}) begin
            errors++;
            $display("FAIL starve_c1 ready=%b raddr=%h want 110 38d",
                     ib.req_ready, ib.prf_raddr);
        end
        tick();
        drive();
        #1;
        checks++;
        if (ib.req_ready !== 3'b001) begin
            errors++;
            $display("FAIL starve_c2 ready=%b want 001", ib.req_ready);
        end
        checks++;
        if (ib.rsp_valid !== 3'b110 || ib.rsp_rs1_data[63:32] !== mem[13]) begin
            errors++;
            $display("FAIL starve_rsp valid=%b d1=%h want 110 %h",
                     ib.rsp_valid, ib.rsp_rs1_data[63:32], mem[13]);
        end
        tick();
        drive();
        #1;
        checks++;
        if (ib.req_ready !== 3'b110) begin
            errors++;
            $display("FAIL starve_c3 ready=%b want 110", ib.req_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        test_reset();
        test_contention();
        test_shared();
        test_zero_need();
        test_flush();
        test_random();
        test_starve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
